// File: rtl/led_bcd_conv_if.sv
// led_bcd_conv_if: conversion request/result bundle between a requester and led_bcd_conv.
interface led_bcd_conv_if;
    logic        start;
    logic [31:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [31:0] num;
    modport master (output start, bin, input busy, done, ovf, num);
    modport slave (input start, bin, output busy, done, ovf, num);
endinterface

// File: rtl/led_bcd_conv.sv
// led_bcd_conv: 32-bit binary to 8-digit packed BCD by serial double-dabble, fixed 32-step latency.
// Optional leading-zero blanking (digits 7..1 -> 4'hF) when LED_BCD_BLANK_EN is defined.
module led_bcd_conv (
    input  logic          clk,
    input  logic          rst_n,
    led_bcd_conv_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t      r_state, w_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_acc, r_sr, r_num;
    logic        r_ovf_next, r_ovf, r_done;
    logic [31:0] w_adj, w_conv, w_res;
    logic        w_last;
    for (genvar d = 0; d < 8; d++) begin : g_adj
        assign w_adj[4*d+:4] = (r_acc[4*d+:4] >= 4'd5) ? r_acc[4*d+:4] + 4'd3 : r_acc[4*d+:4];
    end
    // Value the accumulator will hold after the final step.
    assign w_conv = {w_adj[30:0], r_sr[31]};
`ifdef LED_BCD_BLANK_EN
    always_comb begin : blank_p
        logic lead;
        w_res = w_conv;
        lead  = 1'b1;
        for (int i = 7; i > 0; i--) begin
            lead = lead && (w_conv[4*i+:4] == 4'd0);
            if (lead) w_res[4*i+:4] = 4'hF;
        end
    end
`else
    assign w_res = w_conv;
`endif
    always_comb begin
        w_last  = (r_state == SHIFT) && (r_cnt == 5'd31);
        w_state = (r_state == IDLE) ? (bus.start ? SHIFT : IDLE) : (w_last ? IDLE : SHIFT);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= 5'd0;
            r_acc      <= 32'd0;
            r_sr       <= 32'd0;
            r_num      <= 32'd0;
            r_ovf_next <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state;
            r_done  <= w_last;
            if (r_state == IDLE && bus.start) begin
                r_sr       <= bus.bin;
                r_acc      <= 32'd0;
                r_cnt      <= 5'd0;
                r_ovf_next <= bus.bin > 32'd99_999_999;
            end else if (r_state == SHIFT) begin
                {r_acc, r_sr} <= {w_adj, r_sr} << 1;
                r_cnt         <= r_cnt + 5'd1;
            end
            if (w_last) begin
                r_ovf <= r_ovf_next;
                r_num <= r_ovf_next ? 32'h9999_9999 : w_res;
            end
        end
    end
    assign bus.busy = (r_state == SHIFT);
    assign bus.done = r_done;
    assign bus.ovf  = r_ovf;
    assign bus.num  = r_num;
endmodule
